// File: rtl/gate_truth_table_checker.sv
// Purpose : exhaustive self-checking tester for a small combinational gate; walks every
//           input vector onto stim, samples y after settling, compares with EXPECTED.
// Latency : HOLD_CYCLES+1 cycles per vector; done pulses 2**N_IN*(HOLD_CYCLES+1) edges after start.
// Backpr. : none; start is accepted only in IDLE, starts while running or in DONE are dropped.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   start          begin a run (sampled only in IDLE)
//   y              output of the gate under test
//   stim           registered gate inputs, one vector at a time
//   busy / done    run in progress / one-cycle end-of-run pulse
//   pass           last completed run had zero mismatches
//   err_count      mismatches in the last run
//   fail_vec       bit k set when vector k mismatched in the last run
module gate_truth_table_checker #(
   parameter int                        N_IN        = 2,
   parameter int                        HOLD_CYCLES = 4,
   parameter logic [(2**N_IN)-1:0]      EXPECTED    = 4'b1110
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  y,
   output logic [N_IN-1:0]       stim,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [N_IN:0]         err_count,
   output logic [(2**N_IN)-1:0]  fail_vec
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};
   localparam logic [HW-1:0]   HOLD_END = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   state_t          state;
   logic [N_IN-1:0] idx;
   logic [HW-1:0]   hold_cnt;
   logic            mismatch;
   logic [N_IN:0]   err_next;

   // err_next already includes the vector being checked, so pass can be
   // decided on the same edge as the final comparison.
   always_comb begin
      mismatch = (state == ST_CHECK) && (y != EXPECTED[idx]);
      err_next = err_count + {{N_IN{1'b0}}, mismatch};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         hold_cnt  <= '0;
         stim      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_vec  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= ST_SETTLE;
                  idx       <= '0;
                  hold_cnt  <= '0;
                  stim      <= '0;
                  busy      <= 1'b1;
                  pass      <= 1'b0;
                  err_count <= '0;
                  fail_vec  <= '0;
               end
            end
            ST_SETTLE: begin
               if (hold_cnt == HOLD_END) begin
                  hold_cnt <= '0;
                  state    <= ST_CHECK;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            ST_CHECK: begin
               err_count <= err_next;
               if (mismatch) begin
                  fail_vec[idx] <= 1'b1;
               end
               if (idx == LAST_IDX) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= (err_next == '0);
                  stim  <= '0;
               end else begin
                  idx   <= idx + 1'b1;
                  stim  <= idx + 1'b1;
                  state <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
module tb_gate_truth_table_checker;

   localparam int NV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] gate_sel = 2'd0;   // 0: OR, 1: AND, 2: tie 0, 3: tie 1
   logic [3:0] exp_tt = 4'b1110;

   logic       y [2];
   logic [1:0] stim [2];
   logic       busy [2];
   logic       done [2];
   logic       pass [2];
   logic [2:0] err_count [2];
   logic [3:0] fail_vec [2];

   int n_checks = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   function automatic logic gate_f(input logic [1:0] sel, input logic [1:0] v);
      case (sel)
         2'd0:    return v[1] | v[0];
         2'd1:    return v[1] & v[0];
         2'd2:    return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   assign y[0] = gate_f(gate_sel, stim[0]);
   assign y[1] = gate_f(gate_sel, stim[1]);

   gate_truth_table_checker #(.N_IN(2), .HOLD_CYCLES(4), .EXPECTED(4'b1110)) dut0 (
      .clk(clk), .rst(rst), .start(start), .y(y[0]), .stim(stim[0]), .busy(busy[0]),
      .done(done[0]), .pass(pass[0]), .err_count(err_count[0]), .fail_vec(fail_vec[0]));

   gate_truth_table_checker #(.N_IN(2), .HOLD_CYCLES(1), .EXPECTED(4'b1110)) dut1 (
      .clk(clk), .rst(rst), .start(start), .y(y[1]), .stim(stim[1]), .busy(busy[1]),
      .done(done[1]), .pass(pass[1]), .err_count(err_count[1]), .fail_vec(fail_vec[1]));

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
   endtask

   // Behavioural model: a run is a timeline of t = 0 .. NV*(hold+1) cycles after
   // the accepting edge; vector k sits on stim for t in [k*per, (k+1)*per) and is
   // judged at t = (k+1)*per.
   int         hold_of [2] = '{4, 1};
   bit         m_run [2] = '{0, 0};
   bit         m_done [2] = '{0, 0};
   bit         m_pass [2] = '{0, 0};
   int         m_t [2] = '{0, 0};
   logic [3:0] m_fail [2] = '{4'd0, 4'd0};
   int         per, k;

   always @(posedge clk or posedge rst) begin
      for (int d = 0; d < 2; d++) begin
         per = hold_of[d] + 1;
         if (rst) begin
            m_run[d] = 0; m_done[d] = 0; m_pass[d] = 0; m_t[d] = 0; m_fail[d] = '0;
         end else if (m_run[d]) begin
            m_t[d]++;
            if (m_t[d] % per == 0) begin
               k = m_t[d] / per - 1;
               if (gate_f(gate_sel, 2'(k)) != exp_tt[k]) m_fail[d][k] = 1'b1;
            end
            if (m_t[d] == NV * per) begin
               m_run[d]  = 0;
               m_done[d] = 1;
               m_pass[d] = (m_fail[d] == 4'd0);
            end
         end else if (m_done[d]) begin
            m_done[d] = 0;
         end else if (start) begin
            m_run[d] = 1; m_t[d] = 0; m_fail[d] = '0; m_pass[d] = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("stim dut%0d", d), int'(stim[d]),
                  m_run[d] ? m_t[d] / (hold_of[d] + 1) : 0);
            check($sformatf("busy dut%0d", d), int'(busy[d]), int'(m_run[d]));
            check($sformatf("done dut%0d", d), int'(done[d]), int'(m_done[d]));
            check($sformatf("pass dut%0d", d), int'(pass[d]), int'(m_pass[d]));
            check($sformatf("err_count dut%0d", d), int'(err_count[d]), $countones(m_fail[d]));
            check($sformatf("fail_vec dut%0d", d), int'(fail_vec[d]), int'(m_fail[d]));
         end
      end
   end

   // Starts a run and observes `edges` edges after the accepting edge E0.
   // Reports the edge offsets of done pulses (-1 when absent).
   task automatic run(input bit extra_pulse, input bit hold, input int edges,
                      output int d0a, output int d0b, output int d1a, output int nd0);
      d0a = -1; d0b = -1; d1a = -1; nd0 = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 if (!hold) start = 1'b0;
      for (int n = 1; n <= edges; n++) begin
         @(posedge clk); #1;
         if (done[0]) begin
            nd0++;
            if (d0a < 0) d0a = n; else if (d0b < 0) d0b = n;
         end
         if (done[1] && d1a < 0) d1a = n;
         if (extra_pulse && n == 3) start = 1'b1;
         else if (!hold) start = 1'b0;
      end
      start = 1'b0;
   endtask

   int a0, b0, a1, nd;

   initial begin
      chk_en = 1'b1;
      #3;
      check("reset busy", int'(busy[0]), 0);
      check("reset err_count", int'(err_count[0]), 0);
      #9 rst = 1'b0;

      // OR gate against 1110: clean run
      gate_sel = 2'd0;
      run(0, 0, 24, a0, b0, a1, nd);
      check("or done latency h4", a0, 20);
      check("or done latency h1", a1, 8);
      check("or done count", nd, 1);
      check("or pass", int'(pass[0]), 1);
      check("or fail_vec", int'(fail_vec[0]), 4'b0000);
      check("or pass h1", int'(pass[1]), 1);

      // AND gate: vectors 01 and 10 differ
      gate_sel = 2'd1;
      run(0, 0, 24, a0, b0, a1, nd);
      check("and fail_vec", int'(fail_vec[0]), 4'b0110);
      check("and err_count", int'(err_count[0]), 2);
      check("and pass", int'(pass[0]), 0);

      // tie low, then tie high (previous results must clear)
      gate_sel = 2'd2;
      run(0, 0, 24, a0, b0, a1, nd);
      check("tie0 fail_vec", int'(fail_vec[0]), 4'b1110);
      check("tie0 err_count", int'(err_count[0]), 3);
      gate_sel = 2'd3;
      run(0, 0, 24, a0, b0, a1, nd);
      check("tie1 fail_vec", int'(fail_vec[0]), 4'b0001);
      check("tie1 err_count", int'(err_count[0]), 1);

      // start pulse while busy is ignored
      gate_sel = 2'd0;
      run(1, 0, 30, a0, b0, a1, nd);
      check("busy start done latency", a0, 20);
      check("busy start done count", nd, 1);

      // reset mid-run while stim=10
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      check("pre-reset stim", int'(stim[0]), 2);
      rst = 1'b1;
      #1;
      check("abort stim", int'(stim[0]), 0);
      check("abort busy", int'(busy[0]), 0);
      check("abort done", int'(done[0]), 0);
      check("abort err_count", int'(err_count[0]), 0);
      check("abort fail_vec", int'(fail_vec[0]), 0);
      #1 rst = 1'b0;
      nd = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done[0]) nd++;
      end
      check("no done after abort", nd, 0);
      run(0, 0, 24, a0, b0, a1, nd);
      check("post-abort done latency", a0, 20);
      check("post-abort pass", int'(pass[0]), 1);

      // start held high: restart every time IDLE is re-entered
      gate_sel = 2'd1;
      run(0, 1, 45, a0, b0, a1, nd);
      check("held first done", a0, 20);
      check("held second done", b0, 42);
      check("held h1 first done", a1, 8);
      repeat (25) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
